// File: rtl/drum_pkg.sv
// Shared types, default thresholds and magnitude helper for the drum strike detector.
// The threshold defaults are also used by the MCU packet definition.
package drum_pkg;

   typedef enum logic [1:0] {
      ARMED      = 2'd0,
      QUALIFY    = 2'd1,
      SWING      = 2'd2,
      REFRACTORY = 2'd3
   } strike_state_t;

   localparam int DEF_STRIKE_THRESH     = 2000;
   localparam int DEF_RELEASE_THRESH    = 500;
   localparam int DEF_MIN_SAMPLES       = 2;
   localparam int DEF_MAX_SWING_SAMPLES = 255;
   localparam int DEF_REFRACT_CYCLES    = 300000;

   // |value| as 15-bit unsigned; -32768 saturates to 32767.
   function automatic logic [14:0] abs_sat16(input logic signed [15:0] value);
      if (value == 16'sh8000)
         abs_sat16 = 15'h7fff;
      else if (value[15])
         abs_sat16 = 15'(-value);
      else
         abs_sat16 = value[14:0];
   endfunction

endpackage

// File: rtl/refractory_timer.sv
// Loadable down-counter: counts to zero one step per clk and reports done while at zero.
module refractory_timer
   import drum_pkg::*;
#(
   parameter int COUNT_W = 19
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic [COUNT_W-1:0] count,
   output logic               done
);

   logic [COUNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (clear)
         cnt_reg <= '0;
      else if (load)
         cnt_reg <= count;
      else if (cnt_reg != '0)
         cnt_reg <= cnt_reg - 1'b1;
   end

   assign done = (cnt_reg == '0);

endmodule

// File: rtl/drum_strike_detector.sv
// Gyro-axis drum strike detector: threshold/hysteresis swing tracking with debounce,
// swing timeout and a clock-based refractory lockout after each swing.
module drum_strike_detector
   import drum_pkg::*;
#(
   parameter int STRIKE_THRESH     = DEF_STRIKE_THRESH,
   parameter int RELEASE_THRESH    = DEF_RELEASE_THRESH,
   parameter int MIN_SAMPLES       = DEF_MIN_SAMPLES,
   parameter int MAX_SWING_SAMPLES = DEF_MAX_SWING_SAMPLES,
   parameter int REFRACT_CYCLES    = DEF_REFRACT_CYCLES
) (
   input  logic               clk,
   input  logic               fpga_rst_n,
   input  logic               enable,
   input  logic               gyro_valid,
   input  logic signed [15:0] gyro_axis,
   output logic               hit_valid,
   output logic [14:0]        hit_velocity,
   output logic [7:0]         hit_count,
   output logic [1:0]         state_dbg
);

   localparam int QW = $clog2(MIN_SAMPLES + 1);
   localparam int SW = $clog2(MAX_SWING_SAMPLES + 1);
   localparam int CW = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

   localparam logic signed [15:0] STRIKE_LVL  = 16'(-STRIKE_THRESH);
   localparam logic signed [15:0] RELEASE_LVL = 16'(-RELEASE_THRESH);
   localparam logic [QW-1:0]      QUAL_DONE   = QW'(MIN_SAMPLES);
   localparam logic [SW-1:0]      SWING_LIMIT = SW'(MAX_SWING_SAMPLES);
   localparam logic [CW-1:0]      REFRACT_LD  = CW'(REFRACT_CYCLES - 1);

   strike_state_t state_reg, state_next;
   logic [QW-1:0] qual_reg, qual_next;
   logic [SW-1:0] swing_reg, swing_next;
   logic [14:0]   peak_reg, peak_next;
   logic          hit_valid_reg;
   logic [14:0]   hit_velocity_reg;
   logic [7:0]    hit_count_reg;

   logic [14:0] mag, peak_max;
   logic        qualifying, released, hit_fire, timer_load, timer_done;

   refractory_timer #(.COUNT_W(CW)) u_refractory_timer (
      .clk   (clk),
      .rst_n (fpga_rst_n),
      .clear (!enable),
      .load  (timer_load),
      .count (REFRACT_LD),
      .done  (timer_done)
   );

   assign mag        = abs_sat16(gyro_axis);
   assign peak_max   = (mag > peak_reg) ? mag : peak_reg;
   assign qualifying = (gyro_axis <= STRIKE_LVL);
   assign released   = (gyro_axis > RELEASE_LVL);

   always_comb begin
      state_next = state_reg;
      qual_next  = qual_reg;
      swing_next = swing_reg;
      peak_next  = peak_reg;
      hit_fire   = 1'b0;
      timer_load = 1'b0;
      if (!enable) begin
         state_next = ARMED;
         qual_next  = '0;
         swing_next = '0;
         peak_next  = '0;
      end else begin
         case (state_reg)
            ARMED: if (gyro_valid && qualifying) begin
               qual_next  = QW'(1);
               peak_next  = mag;
               swing_next = '0;
               state_next = (MIN_SAMPLES <= 1) ? SWING : QUALIFY;
            end
            QUALIFY: if (gyro_valid) begin
               if (qualifying) begin
                  qual_next = qual_reg + 1'b1;
                  peak_next = peak_max;
                  if (qual_next == QUAL_DONE) begin
                     state_next = SWING;
                     swing_next = '0;
                  end
               end else begin
                  state_next = ARMED;
                  qual_next  = '0;
                  peak_next  = '0;
               end
            end
            SWING: if (gyro_valid) begin
               swing_next = swing_reg + 1'b1;
               peak_next  = peak_max;
               // A release on the final allowed sample still counts as a hit.
               if (released) begin
                  hit_fire   = 1'b1;
                  timer_load = 1'b1;
                  state_next = REFRACTORY;
               end else if (swing_next == SWING_LIMIT) begin
                  timer_load = 1'b1;
                  state_next = REFRACTORY;
               end
            end
            REFRACTORY: if (timer_done) begin
               state_next = ARMED;
               qual_next  = '0;
               swing_next = '0;
               peak_next  = '0;
            end
            default: state_next = ARMED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         state_reg        <= ARMED;
         qual_reg         <= '0;
         swing_reg        <= '0;
         peak_reg         <= '0;
         hit_valid_reg    <= 1'b0;
         hit_velocity_reg <= '0;
         hit_count_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         qual_reg      <= qual_next;
         swing_reg     <= swing_next;
         peak_reg      <= peak_next;
         hit_valid_reg <= hit_fire;
         if (hit_fire) begin
            hit_velocity_reg <= peak_max;
            hit_count_reg    <= hit_count_reg + 8'd1;
         end
      end
   end

   assign hit_valid    = hit_valid_reg;
   assign hit_velocity = hit_velocity_reg;
   assign hit_count    = hit_count_reg;
   assign state_dbg    = state_reg;

endmodule

// File: tb/tb_drum_strike_detector.sv
// Randomized scoreboard bench for drum_strike_detector against a sample-list reference model.
module tb_drum_strike_detector;

   localparam int ST   = 2000;
   localparam int RT   = 500;
   localparam int MINS = 2;
   localparam int MAXS = 255;
   localparam int RC   = 64;

   logic               clk = 1'b0;
   logic               fpga_rst_n;
   logic               enable;
   logic               gyro_valid;
   logic signed [15:0] gyro_axis;
   logic               hit_valid;
   logic [14:0]        hit_velocity;
   logic [7:0]         hit_count;
   logic [1:0]         state_dbg;

   drum_strike_detector #(
      .STRIKE_THRESH     (ST),
      .RELEASE_THRESH    (RT),
      .MIN_SAMPLES       (MINS),
      .MAX_SWING_SAMPLES (MAXS),
      .REFRACT_CYCLES    (RC)
   ) dut (
      .clk          (clk),
      .fpga_rst_n   (fpga_rst_n),
      .enable       (enable),
      .gyro_valid   (gyro_valid),
      .gyro_axis    (gyro_axis),
      .hit_valid    (hit_valid),
      .hit_velocity (hit_velocity),
      .hit_count    (hit_count),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int vel;
      int cnt;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   sq[$];

   // Reference model: mode, the list of sample magnitudes seen in the current
   // attempt, and an absolute cycle at which the lockout ends.
   int m_mode = 0;
   int m_qual = 0;
   int m_swing = 0;
   int m_mags[$];
   int m_hits = 0;
   int m_vel = 0;
   int m_refr_end = 0;

   function automatic int ref_mag(int v);
      int a;
      a = (v < 0) ? -v : v;
      return (a > 32767) ? 32767 : a;
   endfunction

   function automatic int peak_of_mags();
      int p;
      p = 0;
      foreach (m_mags[i]) if (m_mags[i] > p) p = m_mags[i];
      return p;
   endfunction

   task automatic check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   initial begin : model
      int a;
      int pk;
      forever begin
         @(posedge clk or negedge fpga_rst_n);
         if (!fpga_rst_n) begin
            m_mode = 0; m_qual = 0; m_swing = 0; m_mags.delete();
            m_hits = 0; m_vel = 0; exp_q.delete();
         end else begin
            cyc++;
            a = int'(gyro_axis);
            if (!enable) begin
               m_mode = 0; m_qual = 0; m_swing = 0; m_mags.delete();
            end else if (m_mode == 3) begin
               if (cyc >= m_refr_end) begin
                  m_mode = 0; m_mags.delete();
               end
            end else if (gyro_valid) begin
               if (m_mode == 0) begin
                  if (a <= -ST) begin
                     m_mags.delete(); m_mags.push_back(ref_mag(a));
                     m_qual = 1; m_swing = 0;
                     m_mode = (MINS <= 1) ? 2 : 1;
                  end
               end else if (m_mode == 1) begin
                  if (a <= -ST) begin
                     m_mags.push_back(ref_mag(a));
                     m_qual++;
                     if (m_qual == MINS) begin
                        m_mode = 2; m_swing = 0;
                     end
                  end else begin
                     m_mode = 0; m_qual = 0; m_mags.delete();
                  end
               end else begin
                  m_mags.push_back(ref_mag(a));
                  m_swing++;
                  if (a > -RT) begin
                     pk = peak_of_mags();
                     m_hits++;
                     m_vel = pk;
                     exp_q.push_back('{vel: pk, cnt: m_hits % 256, cyc: cyc});
                     m_mode = 3; m_refr_end = cyc + RC;
                     $display("hit expected cyc=%0d vel=%0d count=%0d", cyc, pk, m_hits % 256);
                  end else if (m_swing == MAXS) begin
                     m_mode = 3; m_refr_end = cyc + RC;
                     $display("swing timeout cyc=%0d", cyc);
                  end
               end
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            check("hit_missing", 0, 1);
         end
         if (hit_valid) begin
            if (exp_q.size() == 0) begin
               check("hit_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("hit_velocity", int'(hit_velocity), e.vel);
               check("hit_count_at_hit", int'(hit_count), e.cnt);
               check("hit_cycle", cyc, e.cyc);
               $display("hit seen cyc=%0d vel=%0d count=%0d", cyc, hit_velocity, hit_count);
            end
         end
         check("state_dbg", int'(state_dbg), m_mode);
         check("hit_count_held", int'(hit_count), m_hits % 256);
         check("hit_velocity_held", int'(hit_velocity), m_vel);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         gyro_valid = 1'b0;
         gyro_axis  = 16'($urandom);
         tick();
      end
   endtask

   task automatic sample(int v);
      gyro_valid = 1'b1;
      gyro_axis  = 16'(v);
      tick();
      idle($urandom_range(0, 2));
   endtask

   task automatic run_seq();
      foreach (sq[i]) sample(sq[i]);
   endtask

   function automatic int rand_val();
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) return -int'($urandom_range(ST, 32768));
      if (r < 7) return -int'($urandom_range(RT, ST - 1));
      return int'($urandom_range(0, 32767 + RT - 1)) - (RT - 1);
   endfunction

   initial begin
      fpga_rst_n = 1'b0;
      enable     = 1'b0;
      gyro_valid = 1'b0;
      gyro_axis  = '0;
      repeat (3) tick();
      check("reset_hit_valid", int'(hit_valid), 0);
      check("reset_state", int'(state_dbg), 0);
      fpga_rst_n = 1'b1;
      enable     = 1'b1;
      idle(2);

      // Basic strike, then debounce rejection
      sq = '{0, -2500, -4000, -6000, -300}; run_seq(); idle(RC + 10);
      sq = '{0, -3000, 0}; run_seq(); idle(3);

      // Second strike inside and after the lockout
      sq = '{-2500, -4000, -300}; run_seq();
      idle(20);
      sq = '{-2500, -4000, -300}; run_seq();
      idle(RC + 1);
      sq = '{-2500, -4000, -300}; run_seq(); idle(RC + 10);

      // Saturation, sustained-rotation timeout, hysteresis
      sq = '{-2500, -32768, -300}; run_seq(); idle(RC + 10);
      sq.delete();
      repeat (MINS + MAXS) sq.push_back(-3000);
      run_seq(); idle(RC + 10);
      sq = '{-2500, -2500, -1000, -1000, -2000, -100}; run_seq(); idle(RC + 10);

      // Enable dropped mid-swing, and enable low on the release sample
      sq = '{-2500, -2500, -3000}; run_seq();
      enable = 1'b0; tick(); enable = 1'b1;
      sample(-300); idle(3);
      sq = '{-2500, -2500, -3000}; run_seq();
      enable = 1'b0; gyro_valid = 1'b1; gyro_axis = -16'sd300; tick();
      enable = 1'b1; idle(3);

      // Reset pulse mid-lockout
      sq = '{-2500, -4000, -300}; run_seq(); idle(10);
      fpga_rst_n = 1'b0; idle(2);
      check("rst_hit_count", int'(hit_count), 0);
      check("rst_hit_velocity", int'(hit_velocity), 0);
      check("rst_state", int'(state_dbg), 0);
      fpga_rst_n = 1'b1; idle(2);

      // Randomized attempts with occasional enable drops
      for (int k = 0; k < 60; k++) begin
         int n;
         n = $urandom_range(2, 10);
         for (int j = 0; j < n; j++) begin
            if ($urandom_range(0, 14) == 0) enable = 1'b0;
            sample(rand_val());
            enable = 1'b1;
         end
         idle($urandom_range(0, 80));
      end
      idle(RC + 10);

      // Counter wrap
      for (int k = 0; k < 256; k++) begin
         sq = '{-2500, -3000, -300}; run_seq(); idle(RC + 2);
      end
      idle(5);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/drum_strike_detector.md
Name: drum_strike_detector

Overview:
- Detects drum strikes from one gyro axis of the right-hand BNO085 stream.
- Sits directly downstream of bno085_controller_new and consumes gyro_valid and one gyro axis.
- Produces a single-cycle hit event carrying a peak-velocity value and a wrapping hit counter.
- These outputs go to the MCU SPI slave packet.
- Uses threshold/hysteresis detection with a debounce count, a swing timeout and a clock-based refractory window.

Parameters:
STRIKE_THRESH, 2000, swing-start magnitude; sample must satisfy gyro_axis <= -STRIKE_THRESH (downward rotation is negative)
RELEASE_THRESH, 500, release magnitude; swing ends when gyro_axis > -RELEASE_THRESH
MIN_SAMPLES, 2, consecutive qualifying samples required to enter SWING
MAX_SWING_SAMPLES, 255, swing samples before abort without a hit
REFRACT_CYCLES, 300000, clk cycles of lockout after a hit (100 ms at 3 MHz)

Ports:
clk  input  1  system clock (3 MHz HSOSC domain)
fpga_rst_n  input  1  asynchronous active-low reset
enable  input  1  sensor initialized; low forces ARMED and suppresses hits
gyro_valid  input  1  one-cycle strobe, new sample on gyro_axis
gyro_axis  input  16  signed angular rate, selected axis
hit_valid  output  1  one-cycle pulse per detected strike
hit_velocity  output  15  unsigned peak magnitude of the swing; held until next hit
hit_count  output  8  number of hits, wraps 255->0
state_dbg  output  2  current FSM state encoding

Behaviour:
- Single clock domain: clk. Reset is asynchronous and active-low on fpga_rst_n.
- Reset values:
  - hit_valid=0, hit_velocity=0, hit_count=0.
  - state=ARMED (state_dbg=0).
  - Internal counters and peak register = 0.
- Magnitude: mag = |gyro_axis|, saturating; -32768 maps to 32767. The result is 15 bits unsigned.
- FSM states: ARMED=0, QUALIFY=1, SWING=2, REFRACTORY=3. Samples are evaluated only on cycles with gyro_valid=1.
- ARMED:
  - On a qualifying sample (gyro_axis <= -STRIKE_THRESH): qual_cnt=1 and peak=mag.
    - If MIN_SAMPLES==1, go directly to SWING.
    - Otherwise go to QUALIFY.
- QUALIFY:
  - Qualifying sample: qual_cnt++ and peak=max(peak,mag). When qual_cnt reaches MIN_SAMPLES, go to SWING with swing_cnt=0.
  - Non-qualifying sample: return to ARMED and clear qual_cnt and peak.
- SWING:
  - Every sample: swing_cnt++ and peak=max(peak,mag).
  - On the first sample with gyro_axis > -RELEASE_THRESH:
    - Registered outputs: hit_valid=1, hit_velocity=peak (peak including this sample), hit_count++.
    - Load refract_cnt=REFRACT_CYCLES-1 and go to REFRACTORY.
  - If swing_cnt reaches MAX_SWING_SAMPLES without a release: go to REFRACTORY with no hit. This covers a sustained rotation.
- REFRACTORY:
  - refract_cnt decrements every clk, independent of gyro_valid.
  - gyro_valid is ignored.
  - At refract_cnt==0, go to ARMED on the next clk.
- Latency: hit_valid is high in the clk after the gyro_valid cycle that carried the release sample. It is exactly one cycle wide.
- Hysteresis: samples between -STRIKE_THRESH and -RELEASE_THRESH neither start nor end a swing.
- enable low (synchronous): next clk is ARMED, all counters and peak clear, hit_valid=0. hit_velocity and hit_count are held, not cleared.
- enable low on the same cycle as a release sample: enable wins and no hit is emitted.
- Reset mid-swing or mid-refractory: immediate return to reset values.
- gyro_valid asserted on consecutive cycles: each cycle is a separate sample. No back-pressure exists.

Decomposition:
- Package drum_pkg holds:
  - State enum strike_state_t (ARMED, QUALIFY, SWING, REFRACTORY, 2-bit).
  - Function abs_sat16 (signed 16 in, unsigned 15 out).
  - Default threshold constants shared with the MCU packet definition.
- One sub-module, refractory_timer: a loadable down-counter sized $clog2(REFRACT_CYCLES). Inputs are load and a count value; output is done.

Test Plan:
- Strike: samples 0, -2500, -4000, -6000, -300 with enable=1 -> one hit_valid pulse one clk after the -300 sample; hit_velocity=6000, hit_count=1.
- Debounce: a single -3000 sample between 0 samples (MIN_SAMPLES=2) -> no hit, state returns to ARMED.
- Refractory: second strike sequence started 1000 clks after the first hit (REFRACT_CYCLES set to 5000 for sim) -> no second hit. The same sequence after 5001 clks -> hit_count=2.
- Saturation/timeout: swing with a -32768 sample then release -> hit_velocity=32767. A separate swing held at -3000 for 255 samples -> no hit, REFRACTORY entered.
- Hysteresis: samples -2500, -2500, -1000, -1000, -2000, -100 -> one hit only, after the -100 sample; hit_velocity=2500.
- Enable/reset/wrap:
  - enable dropped during SWING -> no hit, state_dbg=0 next clk.
  - fpga_rst_n pulsed mid-REFRACTORY -> all outputs 0.
  - 256 hits -> hit_count wraps to 0.
